// File: rtl/jk_pkg.sv
// Shared definitions for the multi-mode flip-flop register bank.
// Mode encodings and the single-bit next-state rule.
package jk_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_D  = 2'b10;
    localparam logic [1:0] MODE_T  = 2'b11;

    // SR with S=R=1 holds; the illegal flag is raised separately.
    function automatic logic next_bit(
        input logic [1:0] mode,
        input logic       q,
        input logic       j,
        input logic       k
    );
        logic n;
        n = q;
        unique case (mode)
            MODE_JK: n = (j & ~q) | (~k & q);
            MODE_SR: n = (j & ~k) | (q & ~(k & ~j));
            MODE_D:  n = j;
            MODE_T:  n = q ^ j;
            default: n = q;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// One storage bit of the register bank: next-state logic and
// the illegal-SR indication for that bit.
module jk_cell
    import jk_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       en,
    input  logic       q,
    input  logic       j,
    input  logic       k,
    output logic       d,
    output logic       ill
);

    assign d   = en ? next_bit(mode, q, j, k) : q;
    assign ill = en & (mode == MODE_SR) & j & k;

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit register of JK/SR/D/T cells with a sticky illegal-SR
// flag, a change pulse and a saturating activity counter.
module jk_register_bank
    import jk_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             chg,
    output logic             sr_err,
    output logic [CNT_W-1:0] act_cnt
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ill;
    logic             chg_q, chg_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .mode (mode),
            .en   (en[i]),
            .q    (q_q[i]),
            .j    (j[i]),
            .k    (k[i]),
            .d    (q_d[i]),
            .ill  (ill[i])
        );
    end

    // A new illegal event outranks a same-edge clear.
    always_comb begin
        chg_d = (q_d != q_q);
        err_d = err_q;
        if (|ill) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
        cnt_d = cnt_q;
        if (chg_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q   <= RESET_VAL;
            chg_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign chg     = chg_q;
    assign sr_err  = err_q;
    assign act_cnt = cnt_q;

endmodule

// File: doc/jk_register_bank.md
# jk_register_bank

Parametrised multi-mode flip-flop register: WIDTH independent storage bits share one clock and one reset. A run-time mode selects how every bit updates: JK, SR, D or T. Each bit has its own enable. The bank also keeps a sticky illegal-SR error flag and a saturating activity counter. It replaces single-bit JK/SR/D/T flip-flop instances wherever a register of such cells is needed.

## Interface
Parameters:
- WIDTH, 8, number of storage bits (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- CNT_W, 16, width of the activity counter (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- mode  input  2  update mode for all bits: 00 JK, 01 SR, 10 D, 11 T
- en  input  WIDTH  per-bit update enable; a bit with en=0 holds
- j  input  WIDTH  J (JK), S (SR), D (D), T (T)
- k  input  WIDTH  K (JK), R (SR), ignored in D and T modes
- err_clr  input  1  synchronous clear of sr_err
- q  output  WIDTH  stored state
- qn  output  WIDTH  ~q, combinational
- chg  output  1  registered; 1 for one cycle after any edge where q changed
- sr_err  output  1  sticky; set on an SR-mode edge with S=R=1 on an enabled bit
- act_cnt  output  CNT_W  saturating count of edges where q changed

## Operation
- Per enabled bit i, at each rising clk edge while rst=1:
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - SR: 00 hold, 01 clear, 10 set, 11 hold (illegal; bit keeps its value and sr_err is set).
  - D: q[i] <= j[i].
  - T: j[i]=1 toggles, j[i]=0 holds.
- A disabled bit always holds, whatever the mode, j and k. It never contributes to sr_err.
- mode is sampled on the same edge as the data. A mode change takes effect on that edge. There is no pipeline.
- sr_err priority: if a new illegal-SR event and err_clr occur on the same edge, the set wins and sr_err stays 1. Otherwise err_clr=1 clears it.
- chg <= (q_next != q). act_cnt increments by 1 on every edge with q_next != q.
- act_cnt saturates at all-ones. It never wraps and is cleared only by reset.

## Timing
- Reset is asynchronous. When rst falls, outputs go immediately to: q=RESET_VAL, qn=~RESET_VAL, chg=0, sr_err=0, act_cnt=0. These hold while rst=0.
- Reset release is sampled at the next rising edge. The first update can occur on the first edge where rst=1.
- Latency: inputs to q is one edge. chg and act_cnt reflect the same edge's change, updated on that edge. sr_err is set on the offending edge.
- qn has zero latency from q.
- A reset asserted mid-operation aborts everything. No partial updates survive it, and the counter does not resume.

## Structure
- Shared package jk_pkg contains:
  - mode localparams MODE_JK=2'b00, MODE_SR=2'b01, MODE_D=2'b10, MODE_T=2'b11
  - a next-state function, next_bit(mode, q, j, k)
- Sub-module jk_cell: one bit. It computes the next state and an illegal-SR flag, and is generated WIDTH times.
- The top module holds the q register, the reduction of the cell flags into sr_err, the change detect, and the saturating counter.

## Test plan
- Reset: rst=0 with RESET_VAL=8'hA5 -> q=A5, qn=5A, chg=0, sr_err=0, act_cnt=0 immediately, before any clk edge.
- JK sequence on bit 0, en=1: JK=00,01,10,11,11 -> q[0] reads 0,0,1,0,1 after successive edges. act_cnt=3.
- SR illegal: mode=01, S=R=1 on bit 2 with en[2]=1 -> q unchanged, sr_err=1. Next edge with err_clr=1 and S=R=1 -> sr_err stays 1. Next edge with err_clr=1 and no illegal input -> sr_err=0.
- Mode switch: mode=10, j=8'h3C -> q=3C. Next edge mode=11, j=8'hFF, en=8'h0F -> q=33, chg=1.
- Saturation: CNT_W=2, T mode with j=1 for 5 edges -> act_cnt reads 1,2,3,3,3.
- Async reset mid-operation: rst dropped between edges during toggling -> all outputs return to reset values without waiting for an edge. The first edge after release applies new inputs.
